// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched: round-robin owner arbitration for a shared 4:1 bit mux.
// Registers the grant, select and selected data bit for the owning requester.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   req[3:0]  in   level requests, one per requester
//   c_in[3:0] in   mux data, c_in[i] belongs to requester i
//   gnt[3:0]  out  one-hot registered grant, zero when idle
//   sel[1:0]  out  registered mux select (holds last value when idle)
//   sel_valid out  high while a grant is active
//   z         out  registered c_in[sel] while granted, else 0
module mux41_rr_sched #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] c_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       z
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold;

  logic [3:0] cand;
  logic [3:0] others;
  logic       pick_any;
  logic [1:0] pick_idx;
  logic [1:0] idx;

  // ptr is always owner+1 while granted, so searching from ptr
  // over the non-owner requests yields "next pending after owner".
  assign others = req & ~gnt;

  always_comb begin
    cand = (state == IDLE) ? req : others;
  end

  // Scan ptr+3 down to ptr so the lowest offset wins last.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = ptr;
    idx      = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (cand[idx]) begin
        pick_any = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold      <= '0;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      z         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= GRANT;
            ptr       <= pick_idx + 2'd1;
            hold      <= '0;
            gnt       <= 4'b0001 << pick_idx;
            sel       <= pick_idx;
            sel_valid <= 1'b1;
            z         <= c_in[pick_idx];
          end else begin
            z <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel] || (hold == H_LAST && pick_any)) begin
            if (pick_any) begin
              ptr       <= pick_idx + 2'd1;
              hold      <= '0;
              gnt       <= 4'b0001 << pick_idx;
              sel       <= pick_idx;
              sel_valid <= 1'b1;
              z         <= c_in[pick_idx];
            end else begin
              state     <= IDLE;
              hold      <= '0;
              gnt       <= '0;
              sel_valid <= 1'b0;
              z         <= 1'b0;
            end
          end else begin
            // Lone owner at the limit keeps the grant; count restarts.
            hold <= (hold == H_LAST) ? '0 : hold + 1'b1;
            z    <= c_in[sel];
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
